residual_checker: RTL and testbench

//  Stage directly downstream of the back-substitution solver. Solver has written x[0..n-1] to the shared

---
 rtl/residual_checker_pkg.sv | 30 +++
 rtl/residual_checker_mac_w.sv | 24 ++
 rtl/residual_checker.sv | 156 +++++++++++++++
 tb/tb_residual_checker.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/residual_checker_pkg.sv
// ============================================================================
// residual_checker_pkg : shared widths, memory opcodes and checker FSM states
// Revision 1.0
// ============================================================================
`default_nettype none

package residual_checker_pkg;

  localparam int RC_W = 20;

  // Memory port opcodes, shared with the back-substitution solver
  localparam logic [2:0] OP_GET_N   = 3'b000;
  localparam logic [2:0] OP_READ_Y  = 3'b001;
  localparam logic [2:0] OP_READ_A  = 3'b010;
  localparam logic [2:0] OP_READ_X  = 3'b011;
  localparam logic [2:0] OP_WRITE_X = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GET_N  = 3'd1,
    ST_READ_Y = 3'd2,
    ST_READ_A = 3'd3,
    ST_READ_X = 3'd4,
    ST_CHECK  = 3'd5,
    ST_DONE   = 3'd6
  } chk_state_t;

endpackage : residual_checker_pkg

`default_nettype wire

// File: rtl/residual_checker_mac_w.sv
// ============================================================================
// mac_w : W-bit multiply-accumulate, acc_out = acc_in + a*b (mod 2^W)
// Revision 1.0
// ============================================================================
`default_nettype none

module mac_w #(
  parameter int W = 20
) (
  input  logic [W-1:0] acc_in,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] acc_out
);

  logic [W-1:0] prod;

  // Self-determined W-bit operands keep both product and sum truncated to W bits
  assign prod    = a * b;
  assign acc_out = acc_in + prod;

endmodule : mac_w

`default_nettype wire

// File: rtl/residual_checker.sv
// ============================================================================
// residual_checker : re-reads n, Y, A, x and counts rows with Y[i] != A[i]*x
// Revision 1.0
// ============================================================================
`default_nettype none

module residual_checker
  import residual_checker_pkg::*;
#(
  parameter int W = RC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] in_data,
  output logic [2:0]   opcode,
  output logic [W-1:0] i,
  output logic [W-1:0] j,
  output logic [W-1:0] err_cnt,
  output logic [W-1:0] first_bad_row,
  output logic         pass,
  output logic         fin
);

  localparam logic [W-1:0] ONE_W   = W'(1);
  localparam logic [W-1:0] ZERO_W  = '0;
  localparam logic [W-1:0] MAX_CNT = '1;

  chk_state_t   state;
  logic [W-1:0] n;
  logic [W-1:0] r;
  logic [W-1:0] c;
  logic [W-1:0] acc;
  logic [W-1:0] y_l;
  logic [W-1:0] a_l;

  logic [W-1:0] mac_out;
  logic [W-1:0] residual;
  logic         row_bad;
  logic [W-1:0] err_next;
  logic         last_col;
  logic         last_row;

  mac_w #(.W(W)) u_mac (
    .acc_in  (acc),
    .a       (a_l),
    .b       (in_data),
    .acc_out (mac_out)
  );

  assign residual = y_l - acc;
  assign row_bad  = (residual != ZERO_W);
  assign err_next = (row_bad && (err_cnt != MAX_CNT)) ? err_cnt + ONE_W : err_cnt;
  assign last_col = (c == n - ONE_W);
  assign last_row = (r == n - ONE_W);

  // Memory request is a pure decode of state and counters
  always_comb begin
    opcode = OP_GET_N;
    i      = ZERO_W;
    j      = ZERO_W;
    case (state)
      ST_READ_Y: begin
        opcode = OP_READ_Y;
        i      = r;
      end
      ST_READ_A: begin
        opcode = OP_READ_A;
        i      = r;
        j      = c;
      end
      ST_READ_X: begin
        opcode = OP_READ_X;
        i      = c;
      end
      default: begin
        opcode = OP_GET_N;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      n             <= ZERO_W;
      r             <= ZERO_W;
      c             <= ZERO_W;
      acc           <= ZERO_W;
      y_l           <= ZERO_W;
      a_l           <= ZERO_W;
      err_cnt       <= ZERO_W;
      first_bad_row <= ZERO_W;
      pass          <= 1'b0;
      fin           <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_GET_N;
        end
        ST_GET_N: begin
          n             <= in_data;
          r             <= ZERO_W;
          err_cnt       <= ZERO_W;
          first_bad_row <= ZERO_W;
          if (in_data == ZERO_W) begin
            state <= ST_DONE;
            fin   <= 1'b1;
            pass  <= 1'b1;
          end else begin
            state <= ST_READ_Y;
          end
        end
        ST_READ_Y: begin
          y_l   <= in_data;
          acc   <= ZERO_W;
          c     <= ZERO_W;
          state <= ST_READ_A;
        end
        ST_READ_A: begin
          a_l   <= in_data;
          state <= ST_READ_X;
        end
        ST_READ_X: begin
          acc   <= mac_out;
          c     <= c + ONE_W;
          state <= last_col ? ST_CHECK : ST_READ_A;
        end
        ST_CHECK: begin
          err_cnt <= err_next;
          if (row_bad && (err_cnt == ZERO_W)) first_bad_row <= r;
          if (last_row) begin
            state <= ST_DONE;
            fin   <= 1'b1;
            pass  <= (err_next == ZERO_W);
          end else begin
            r     <= r + ONE_W;
            state <= ST_READ_Y;
          end
        end
        ST_DONE: begin
          if (start) begin
            state <= ST_GET_N;
            fin   <= 1'b0;
            pass  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : residual_checker

`default_nettype wire

// File: tb/tb_residual_checker.sv
// ============================================================================
// tb_residual_checker : directed vectors against a behavioural matrix memory
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_residual_checker;

  localparam int W = 20;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] in_data;
  logic [2:0]   opcode;
  logic [W-1:0] i;
  logic [W-1:0] j;
  logic [W-1:0] err_cnt;
  logic [W-1:0] first_bad_row;
  logic         pass;
  logic         fin;

  logic [W-1:0] mem_n;
  logic [W-1:0] mem_y [0:7];
  logic [W-1:0] mem_x [0:7];
  logic [W-1:0] mem_a [0:7][0:7];

  int total = 0;
  int bad   = 0;
  int cycles;
  logic [2:0] trace [0:63];
  logic       saw_row_op;

  residual_checker #(.W(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .in_data       (in_data),
    .opcode        (opcode),
    .i             (i),
    .j             (j),
    .err_cnt       (err_cnt),
    .first_bad_row (first_bad_row),
    .pass          (pass),
    .fin           (fin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    in_data = '0;
    case (opcode)
      3'b000: in_data = mem_n;
      3'b001: in_data = mem_y[i[2:0]];
      3'b010: in_data = mem_a[i[2:0]][j[2:0]];
      3'b011: in_data = mem_x[i[2:0]];
      default: in_data = '0;
    endcase
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    mem_n = '0;
    for (int r = 0; r < 8; r++) begin
      mem_y[r] = '0;
      mem_x[r] = '0;
      for (int c = 0; c < 8; c++) mem_a[r][c] = '0;
    end
  endtask

  task automatic load_case3();
    clear_mem();
    mem_n = 3;
    mem_a[0][0] = 2; mem_a[0][1] = 1; mem_a[0][2] = 1;
    mem_a[1][1] = 3; mem_a[1][2] = 2;
    mem_a[2][2] = 4;
    mem_x[0] = 1; mem_x[1] = 2; mem_x[2] = 3;
    mem_y[0] = 7; mem_y[1] = 12; mem_y[2] = 12;
  endtask

  // Pulse start, then count edges (after the sampling edge) until fin rises
  task automatic run_check(output int cyc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    saw_row_op = 1'b0;
    while (!fin && cyc < 500) begin
      if (cyc < 64) trace[cyc] = opcode;
      if (opcode != 3'b000) saw_row_op = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 500) check_val("fin_timeout", 32'(cyc), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_fin", 32'(fin), 32'd0);
    check_val("rst_pass", 32'(pass), 32'd0);
    check_val("rst_err", 32'(err_cnt), 32'd0);
    check_val("rst_fbr", 32'(first_bad_row), 32'd0);
    check_val("rst_op", 32'(opcode), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: n=0
    clear_mem();
    run_check(cycles);
    check_val("n0_lat", 32'(cycles), 32'd1);
    check_val("n0_pass", 32'(pass), 32'd1);
    check_val("n0_err", 32'(err_cnt), 32'd0);
    check_val("n0_rowops", 32'(saw_row_op), 32'd0);

    // 2: n=1, 3*2 == 6; restart from DONE
    clear_mem();
    mem_n = 1; mem_a[0][0] = 3; mem_y[0] = 6; mem_x[0] = 2;
    run_check(cycles);
    check_val("n1_lat", 32'(cycles), 32'd5);
    check_val("n1_pass", 32'(pass), 32'd1);
    check_val("n1_err", 32'(err_cnt), 32'd0);
    check_val("n1_tr0", 32'(trace[0]), 32'd0);
    check_val("n1_tr1", 32'(trace[1]), 32'd1);
    check_val("n1_tr2", 32'(trace[2]), 32'd2);
    check_val("n1_tr3", 32'(trace[3]), 32'd3);
    check_val("n1_tr4", 32'(trace[4]), 32'd0);

    // 3: upper-triangular 3x3, consistent solution
    load_case3();
    run_check(cycles);
    check_val("c3_lat", 32'(cycles), 32'd25);
    check_val("c3_pass", 32'(pass), 32'd1);
    check_val("c3_err", 32'(err_cnt), 32'd0);
    check_val("c3_fbr", 32'(first_bad_row), 32'd0);

    // 4: x[1]=5 -> rows 0 (10!=7) and 1 (21!=12) fail
    load_case3();
    mem_x[1] = 5;
    run_check(cycles);
    check_val("c4_pass", 32'(pass), 32'd0);
    check_val("c4_err", 32'(err_cnt), 32'd2);
    check_val("c4_fbr", 32'(first_bad_row), 32'd0);
    check_val("c4_fin", 32'(fin), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check_val("c4_hold_err", 32'(err_cnt), 32'd2);

    // 4b: only last row wrong -> first_bad_row=2
    load_case3();
    mem_y[2] = 13;
    run_check(cycles);
    check_val("c4b_pass", 32'(pass), 32'd0);
    check_val("c4b_err", 32'(err_cnt), 32'd1);
    check_val("c4b_fbr", 32'(first_bad_row), 32'd2);

    // 5: 2^19 * 2 wraps to 0
    clear_mem();
    mem_n = 1; mem_a[0][0] = 20'h80000; mem_x[0] = 2; mem_y[0] = 0;
    run_check(cycles);
    check_val("wrap_pass", 32'(pass), 32'd1);
    check_val("wrap_err", 32'(err_cnt), 32'd0);

    // 6: async reset during READ_X of row 1, then rerun case 3
    load_case3();
    mem_x[1] = 5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check_val("c6_in_readx", 32'(opcode), 32'd3);
    check_val("c6_readx_i", 32'(i), 32'd0);
    rst_n = 1'b0;
    #1;
    check_val("c6_rst_fin", 32'(fin), 32'd0);
    check_val("c6_rst_err", 32'(err_cnt), 32'd0);
    check_val("c6_rst_pass", 32'(pass), 32'd0);
    check_val("c6_rst_op", 32'(opcode), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_case3();
    run_check(cycles);
    check_val("c6_lat", 32'(cycles), 32'd25);
    check_val("c6_pass", 32'(pass), 32'd1);
    check_val("c6_err", 32'(err_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule : tb_residual_checker

`default_nettype wire
